// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory with variable wait states, and hands each fetched instruction to
// decode over a valid/ready handshake. Redirects flush any in-flight fetch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        FLUSH,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        halt_pending;
    logic        misaligned;
    logic        flush_halt;
    logic [31:0] flush_pc;

    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Once a halt is pending, further redirects in FLUSH are irrelevant.
    assign flush_halt = halt_pending || misaligned;
    assign flush_pc   = (redirect_valid && !misaligned) ? redirect_pc : pc;

    // Fetch state machine; every output is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            halt_pending   <= 1'b0;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            instr_pc       <= 32'h0000_0000;
            misaligned_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        misaligned_err <= 1'b1;
                        state          <= HALT;
                    end else begin
                        pc        <= redirect_valid ? redirect_pc : pc;
                        imem_addr <= redirect_valid ? redirect_pc : pc;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (misaligned) begin
                            misaligned_err <= 1'b1;
                            if (imem_ready) begin
                                imem_req <= 1'b0;
                                state    <= HALT;
                            end else begin
                                halt_pending <= 1'b1;
                                state        <= FLUSH;
                            end
                        end else begin
                            pc <= redirect_pc;
                            if (imem_ready) begin
                                imem_addr <= redirect_pc;
                                state     <= REQ;
                            end else begin
                                state <= FLUSH;
                            end
                        end
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (misaligned) begin
                            misaligned_err <= 1'b1;
                            state          <= HALT;
                        end else begin
                            pc        <= redirect_pc;
                            imem_addr <= redirect_pc;
                            imem_req  <= 1'b1;
                            state     <= REQ;
                        end
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        imem_addr   <= pc;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end

                FLUSH: begin
                    if (redirect_valid && !halt_pending) begin
                        if (misaligned) begin
                            misaligned_err <= 1'b1;
                            halt_pending   <= 1'b1;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end
                    if (imem_ready) begin
                        if (flush_halt) begin
                            imem_req <= 1'b0;
                            state    <= HALT;
                        end else begin
                            imem_addr <= flush_pc;
                            state     <= REQ;
                        end
                    end
                end

                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned_err;

    int assertCount = 0;
    int failCount   = 0;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned_err (misaligned_err)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic iready,
                                 input logic rv, input logic [31:0] rpc);
        imem_ready     = rdy;
        imem_rdata     = rdata;
        instr_ready    = iready;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr, input logic valid);
        checkOutput({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) checkOutput({tag, "_addr"}, imem_addr, addr);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, valid});
    endtask

    // Directed scenario sequence.
    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_instr", instr, NOP);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_err", {31'd0, misaligned_err}, 32'd0);

        // Back-to-back fetches with zero wait states
        reset = 1'b1;
        tick();
        checkFetch("f1_issue", 1'b1, 32'h0040_0000, 1'b0);
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("f1_done", 1'b0, 32'h0, 1'b1);
        checkOutput("f1_instr", instr, 32'h0050_0093);
        checkOutput("f1_pc", instr_pc, 32'h0040_0000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkFetch("f2_issue", 1'b1, 32'h0040_0004, 1'b0);
        checkOutput("f2_nop", instr, NOP);
        applyStimulus(1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("f2_done", 1'b0, 32'h0, 1'b1);
        checkOutput("f2_instr", instr, 32'h00A0_0113);
        checkOutput("f2_pc", instr_pc, 32'h0040_0004);
        checkOutput("f2_err", {31'd0, misaligned_err}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkFetch("f3_issue", 1'b1, 32'h0040_0008, 1'b0);

        // Three wait states, then decode stalls four cycles
        applyStimulus(1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkFetch("ws_wait", 1'b1, 32'h0040_0008, 1'b0);
        end
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkFetch("stall", 1'b0, 32'h0, 1'b1);
            checkOutput("stall_instr", instr, 32'h0050_0093);
            checkOutput("stall_pc", instr_pc, 32'h0040_0008);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkFetch("f4_issue", 1'b1, 32'h0040_000C, 1'b0);

        // Redirect while a request is in flight
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0100);
        tick();
        checkFetch("flush_hold", 1'b1, 32'h0040_000C, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("flush_wait", 1'b1, 32'h0040_000C, 1'b0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("flush_drop", 1'b1, 32'h0040_0100, 1'b0);
        checkOutput("flush_instr", instr, NOP);

        // Redirect and accept in the same HOLD cycle
        applyStimulus(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("tgt_pc", instr_pc, 32'h0040_0100);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0040);
        tick();
        checkFetch("hold_redir", 1'b1, 32'h0040_0040, 1'b0);

        // PC wraps at the top of the address space
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        checkFetch("wrap_issue", 1'b1, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkFetch("wrap_next", 1'b1, 32'h0000_0000, 1'b0);
        checkOutput("wrap_err", {31'd0, misaligned_err}, 32'd0);

        // Redirect coincident with the memory response in REQ
        applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h0040_0200);
        tick();
        checkFetch("req_redir", 1'b1, 32'h0040_0200, 1'b0);
        checkOutput("req_redir_instr", instr, NOP);

        // Misaligned redirect: drain in-flight fetch, then halt
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0102);
        tick();
        checkOutput("mis_err", {31'd0, misaligned_err}, 32'd1);
        checkFetch("mis_drain", 1'b1, 32'h0040_0200, 1'b0);
        applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("halt", 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h4444_4444, 1'b1, 1'b1, 32'h0040_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkFetch("halt_stuck", 1'b0, 32'h0, 1'b0);
            checkOutput("halt_err", {31'd0, misaligned_err}, 32'd1);
        end

        // Reset leaves HALT and restarts at the reset vector
        reset = 1'b0;
        #1;
        checkOutput("rst2_err", {31'd0, misaligned_err}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        checkFetch("restart", 1'b1, 32'h0040_0000, 1'b0);
        checkOutput("restart_err", {31'd0, misaligned_err}, 32'd0);

        // Asynchronous reset mid-request drops the request; late ready ignored
        reset = 1'b0;
        #1;
        checkOutput("async_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("late_ready", 1'b0, 32'h0, 1'b0);
        checkOutput("late_instr", instr, NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate/sign-extend logic and the decoder.
- Holds the program counter and issues word requests to instruction memory, which may take one or more cycles to respond (variable wait states).
- Captures each returned instruction into an output register and presents it, with its PC, to the decode stage through a valid/ready handshake.
- Accepts branch/jump redirects and flushes any fetch already in flight.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (first fetch address)
NOP_INSTR, 32'h0000_0013, value of instr while no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  instruction memory request
imem_addr  output  32  word address of request (PC)
imem_ready  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ready=1
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr  output  32  fetched instruction to decode/sign-extend
instr_pc  output  32  PC of instr
instr_ready  input  1  decode consumes instr this cycle
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  redirect target
misaligned_err  output  1  sticky: redirect target not word aligned

Behaviour:
- Reset values, applied immediately when reset goes low:
  - pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0
  - instr=NOP_INSTR, instr_pc=0, misaligned_err=0
- States: IDLE, REQ, HOLD, FLUSH, HALT.
- imem_req=1 only in REQ and FLUSH. imem_addr=pc in REQ; in FLUSH it holds the address that was in flight.
- IDLE: on the first clock edge after reset is released, go to REQ.
- REQ:
  - imem_req and imem_addr are held stable until imem_ready=1.
  - On imem_ready: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
  - Minimum latency: imem_req rises, and with zero wait states instr_valid rises 1 cycle later.
- HOLD:
  - instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - On instr_ready: instr_valid<=0, instr<=NOP_INSTR, go to REQ.
  - Throughput is 1 instruction per 2 cycles at zero wait states.
- Redirect (redirect_valid=1) has priority over every other event in IDLE, REQ and HOLD:
  - pc<=redirect_pc, instr_valid<=0, instr<=NOP_INSTR.
  - In IDLE or HOLD: go to REQ. In HOLD with instr_ready=1 in the same cycle, the instruction counts as consumed and the redirect is still applied.
  - In REQ with imem_ready=1 in the same cycle: discard imem_rdata and go to REQ (the new address is issued next cycle).
  - In REQ with imem_ready=0: go to FLUSH. The transaction already in flight is never aborted.
- FLUSH:
  - Hold the old request until imem_ready, discard that data, then go to REQ with the redirected pc.
  - A further redirect while in FLUSH overwrites pc; the state stays FLUSH.
- Misalignment:
  - If redirect_valid=1 and redirect_pc[1:0]!=0: misaligned_err<=1, instr_valid<=0, go to HALT.
  - If a request is in flight, finish it as in FLUSH first (data discarded), then go to HALT.
  - HALT: imem_req=0, all inputs ignored; only reset exits.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC+4 = 32'h0000_0000, with no error.
- imem_rdata is ignored whenever imem_ready=0 or the state is not REQ/FLUSH.
- Reset asserted mid-transaction drops imem_req asynchronously. Any late imem_ready after that is ignored.

Test Plan:
- Reset, then imem_ready=1 every cycle with rdata 32'h00500093, 32'h00A00113 -> imem_addr 0x00400000 then 0x00400004; instr_valid rises 1 cycle after each req; instr_pc matches the address; misaligned_err=0.
- 3 wait states on the first fetch, and instr_ready held low 4 cycles in HOLD -> imem_addr stable for 4 cycles; instr stays 32'h00500093 for all 4 cycles; no second req until accept.
- In REQ with imem_ready=0, redirect_pc=0x00400100; memory answers 2 cycles later -> that data is dropped (instr_valid stays 0); next imem_addr is 0x00400100.
- In HOLD, redirect_valid and instr_ready in the same cycle, target 0x00400040 -> instr_valid=0 next cycle; next request is at 0x00400040.
- redirect_pc=0x00400102 -> misaligned_err=1 sticky, imem_req=0 until reset; reset low then high -> fetch restarts at 0x00400000 with misaligned_err=0.
- redirect_pc=0xFFFFFFFC, fetch completes -> pc wraps to 0x00000000, next imem_addr=0x00000000, no error.
